// File: rtl/avalon_st_packet_gate_if.sv
// ---------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST style streaming link used on both sides of avalon_st_packet_gate.
//
// Parameters:
//   DATA_WIDTH_IN_BYTES  bytes per beat; data is 8*DATA_WIDTH_IN_BYTES bits
//                        wide and empty is $clog2(DATA_WIDTH_IN_BYTES) bits
//
// Signals:
//   data   beat payload
//   sop    start-of-packet marker
//   eop    end-of-packet marker
//   empty  number of unused bytes in an eop beat
//   valid  source has a beat on the link
//   rdy    sink can take the beat this cycle
//
// Modports:
//   master  drives data/sop/eop/empty/valid, receives rdy
//   slave   receives data/sop/eop/empty/valid, drives rdy
// ---------------------------------------------------------------------------
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_WIDTH-1:0]           empty;
    logic                             valid;
    logic                             rdy;

    modport master (output data, output sop, output eop, output empty, output valid, input rdy);
    modport slave  (input data, input sop, input eop, input empty, input valid, output rdy);
endinterface

// File: rtl/avalon_st_packet_gate.sv
// ---------------------------------------------------------------------------
// avalon_st_packet_gate
// Packet-boundary-aware admission gate between two avalon_st_if links. The
// enable input is only looked at when a start-of-packet beat is accepted
// between packets, so a packet that has been admitted is always forwarded
// whole, and a packet that has been refused is refused whole. Refused
// traffic is either back-pressured (BLOCK) or swallowed (DROP). The forward
// path has a one-beat output register and sustains one beat per clock.
//
// Parameters:
//   DATA_WIDTH_IN_BYTES  bytes per beat on msg_in/msg_out
//   DROP_MODE            0 = BLOCK (rdy low while closed), 1 = DROP
//   CNT_WIDTH            statistics counter width (stats build only)
//
// Optional feature macro: AVALON_ST_PACKET_GATE_STATS_EN
//   When defined, pkt_pass_cnt/pkt_drop_cnt ports and their saturating
//   counters are present; when undefined they do not exist at all.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   msg_in        slave stream (input traffic)
//   msg_out       master stream (admitted traffic, one cycle later)
//   enable        admission request, sampled on an accepted sop in GAP
//   busy          high while a packet is in flight (PASS or DISCARD)
//   proto_err     one-cycle pulse on an orphan beat or a premature sop
//   pkt_pass_cnt  packets forwarded (stats build only)
//   pkt_drop_cnt  packets discarded (stats build only)
// ---------------------------------------------------------------------------
module avalon_st_packet_gate #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int DROP_MODE           = 0
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
    ,
    parameter int CNT_WIDTH           = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    avalon_st_if.slave        msg_in,
    avalon_st_if.master       msg_out,
    input  logic              enable,
    output logic              busy,
    output logic              proto_err
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] pkt_pass_cnt,
    output logic [CNT_WIDTH-1:0] pkt_drop_cnt
`endif
);

    localparam int DATA_WIDTH  = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    typedef enum logic [1:0] {
        GAP     = 2'd0,
        PASS    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic                   out_valid;
    logic                   out_sop;
    logic                   out_eop;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [EMPTY_WIDTH-1:0] out_empty;

    logic                   out_free;
    logic                   in_rdy;
    logic                   fwd;
    logic                   err_nxt;
    logic                   premature;
    logic                   gap_eval;

    assign out_free      = !out_valid || msg_out.rdy;
    assign msg_in.rdy    = in_rdy;
    assign msg_out.valid = out_valid;
    assign msg_out.sop   = out_sop;
    assign msg_out.eop   = out_eop;
    assign msg_out.data  = out_data;
    assign msg_out.empty = out_empty;
    assign busy          = (state != GAP);

    // Next-state and handshake decode. A sop arriving while a packet is
    // still open closes that packet on the spot and is then judged exactly
    // like a sop seen between packets, so the GAP rules are shared through
    // gap_eval. In BLOCK mode a refused premature sop is not accepted, but
    // the state still falls back to GAP so the error is reported only once.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        fwd       = 1'b0;
        err_nxt   = 1'b0;
        premature = (state != GAP) && msg_in.valid && msg_in.sop;
        gap_eval  = (state == GAP) || premature;

        if (premature) begin
            err_nxt   = 1'b1;
            state_nxt = GAP;
        end

        if (gap_eval) begin
            in_rdy = enable ? out_free : (DROP_MODE != 0);
            if (msg_in.valid && in_rdy) begin
                if (msg_in.sop) begin
                    if (enable) begin
                        fwd = 1'b1;
                        if (!msg_in.eop) begin
                            state_nxt = PASS;
                        end
                    end else if (!msg_in.eop) begin
                        state_nxt = DISCARD;
                    end
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end else if (state == PASS) begin
            in_rdy = out_free;
            if (msg_in.valid && in_rdy) begin
                fwd = 1'b1;
                if (msg_in.eop) begin
                    state_nxt = GAP;
                end
            end
        end else begin
            in_rdy = 1'b1;
            if (msg_in.valid && msg_in.eop) begin
                state_nxt = GAP;
            end
        end
    end

    // State register and the registered protocol-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GAP;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            proto_err <= err_nxt;
        end
    end

    // Output register. A forwarded beat is loaded whenever the slot is free
    // (fwd already implies out_free); otherwise the slot empties once the
    // sink takes it, and the payload fields are left untouched so they stay
    // stable for a stalled sink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_empty <= '0;
        end else if (fwd) begin
            out_valid <= 1'b1;
            out_sop   <= msg_in.sop;
            out_eop   <= msg_in.eop;
            out_data  <= msg_in.data;
            out_empty <= msg_in.empty;
        end else if (msg_out.rdy) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AVALON_ST_PACKET_GATE_STATS_EN
    logic       pass_inc;
    logic       new_drop;
    logic [1:0] drop_inc;

    // Counter increments. A packet cut short by a premature sop never saw
    // its eop downstream, so it is booked as dropped whether it was being
    // forwarded or discarded. The same beat may also be a refused
    // single-beat packet, which is why a drop can count twice in one cycle.
    // Orphan beats are not packets and are not counted.
    always_comb begin
        pass_inc = fwd && msg_in.eop;
        new_drop = msg_in.valid && in_rdy && !fwd && msg_in.eop &&
                   (msg_in.sop || (state == DISCARD));
        drop_inc = {1'b0, premature} + {1'b0, new_drop};
    end

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH+1:0] sum;
        sum = {2'b00, cnt} + {{CNT_WIDTH{1'b0}}, inc};
        return (sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // Statistics counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_pass_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            pkt_pass_cnt <= sat_add(pkt_pass_cnt, {1'b0, pass_inc});
            pkt_drop_cnt <= sat_add(pkt_drop_cnt, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_avalon_st_packet_gate.sv
// ---------------------------------------------------------------------------
// tb_avalon_st_packet_gate
// Bench for avalon_st_packet_gate. Instance 0 runs in BLOCK mode, instance 1
// in DROP mode; each has its own driver slot in the drv_* arrays.
// ---------------------------------------------------------------------------
module tb_avalon_st_packet_gate;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in_b ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out_b ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in_d ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out_d ();

    logic         drv_valid [2];
    logic         drv_sop   [2];
    logic         drv_eop   [2];
    logic [127:0] drv_data  [2];
    logic [3:0]   drv_empty [2];
    logic         drv_en    [2];
    logic         drv_ordy  [2];

    logic         mon_irdy  [2];
    logic         mon_ovld  [2];
    logic         mon_osop  [2];
    logic         mon_oeop  [2];
    logic [127:0] mon_odata [2];
    logic [3:0]   mon_oempty[2];
    logic         busy_w    [2];
    logic         perr_w    [2];
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
    logic [1:0]   pass_cnt_w[2];
    logic [1:0]   drop_cnt_w[2];
`endif

    assign in_b.valid = drv_valid[0];
    assign in_b.sop   = drv_sop[0];
    assign in_b.eop   = drv_eop[0];
    assign in_b.data  = drv_data[0];
    assign in_b.empty = drv_empty[0];
    assign out_b.rdy  = drv_ordy[0];
    assign in_d.valid = drv_valid[1];
    assign in_d.sop   = drv_sop[1];
    assign in_d.eop   = drv_eop[1];
    assign in_d.data  = drv_data[1];
    assign in_d.empty = drv_empty[1];
    assign out_d.rdy  = drv_ordy[1];

    assign mon_irdy[0]   = in_b.rdy;
    assign mon_ovld[0]   = out_b.valid;
    assign mon_osop[0]   = out_b.sop;
    assign mon_oeop[0]   = out_b.eop;
    assign mon_odata[0]  = out_b.data;
    assign mon_oempty[0] = out_b.empty;
    assign mon_irdy[1]   = in_d.rdy;
    assign mon_ovld[1]   = out_d.valid;
    assign mon_osop[1]   = out_d.sop;
    assign mon_oeop[1]   = out_d.eop;
    assign mon_odata[1]  = out_d.data;
    assign mon_oempty[1] = out_d.empty;

    avalon_st_packet_gate #(
        .DATA_WIDTH_IN_BYTES(16),
        .DROP_MODE(0)
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        ,
        .CNT_WIDTH(2)
`endif
    ) u_block (
        .clk(clk),
        .rst_n(rst_n),
        .msg_in(in_b),
        .msg_out(out_b),
        .enable(drv_en[0]),
        .busy(busy_w[0]),
        .proto_err(perr_w[0])
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        ,
        .pkt_pass_cnt(pass_cnt_w[0]),
        .pkt_drop_cnt(drop_cnt_w[0])
`endif
    );

    avalon_st_packet_gate #(
        .DATA_WIDTH_IN_BYTES(16),
        .DROP_MODE(1)
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        ,
        .CNT_WIDTH(2)
`endif
    ) u_drop (
        .clk(clk),
        .rst_n(rst_n),
        .msg_in(in_d),
        .msg_out(out_d),
        .enable(drv_en[1]),
        .busy(busy_w[1]),
        .proto_err(perr_w[1])
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        ,
        .pkt_pass_cnt(pass_cnt_w[1]),
        .pkt_drop_cnt(drop_cnt_w[1])
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        forever #5 clk = ~clk;
    end

    // One table row: inputs {valid,sop,eop,enable,out_rdy} and a data byte,
    // then the expected {in_rdy,out_valid,out_sop,out_eop}, output byte and
    // {busy,proto_err} seen in that same cycle.
    typedef struct packed {
        logic [4:0] in_bits;
        logic [7:0] d;
        logic [3:0] exp_bits;
        logic [7:0] od;
        logic [1:0] bp;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the
    // falling edge so the caller can sample settled outputs.
    task automatic applyStimulus(input int m, input logic v, input logic s, input logic e,
                                 input logic en, input logic ordy, input logic [7:0] d);
        @(posedge clk);
        #1;
        drv_valid[m] = v;
        drv_sop[m]   = s;
        drv_eop[m]   = e;
        drv_en[m]    = en;
        drv_ordy[m]  = ordy;
        drv_data[m]  = {16{d}};
        drv_empty[m] = d[3:0];
        @(negedge clk);
    endtask

    task automatic resetDut();
        for (int k = 0; k < 2; k++) begin
            drv_valid[k] = 1'b0;
            drv_sop[k]   = 1'b0;
            drv_eop[k]   = 1'b0;
            drv_en[k]    = 1'b0;
            drv_ordy[k]  = 1'b1;
            drv_data[k]  = '0;
            drv_empty[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset%0d", k),
                        {mon_ovld[k], mon_osop[k], mon_oeop[k], mon_odata[k], mon_oempty[k],
                         busy_w[k], perr_w[k]}, '0);
        end
        rst_n = 1'b1;
    endtask

    // Randomised packet traffic on instance m, checked at transaction level:
    // a packet is forwarded whole iff enable was high when its sop was taken,
    // every accepted orphan gives one proto_err pulse, and the forwarded beat
    // sequence must come out in order, unaltered, with nothing extra.
    task automatic runRandom(input int m);
        beat_t stim[$];
        beat_t expq[$];
        beat_t b;
        beat_t o;
        int    idx = 0;
        int    cyc = 0;
        int    exp_err = 0;
        int    act_err = 0;
        int    exp_pass = 0;
        int    exp_drop = 0;
        bit    admitted = 1'b0;
        bit    inpkt = 1'b0;
        bit    taken = 1'b0;
        int    len;

        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 5) == 0) begin
                b.data  = {$urandom, $urandom, $urandom, $urandom};
                b.sop   = 1'b0;
                b.eop   = 1'b0;
                b.empty = 4'($urandom_range(0, 15));
                stim.push_back(b);
            end
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                b.data  = {$urandom, $urandom, $urandom, $urandom};
                b.sop   = (i == 0);
                b.eop   = (i == len - 1);
                b.empty = 4'($urandom_range(0, 15));
                stim.push_back(b);
            end
        end

        drv_valid[m] = 1'b0;
        while ((idx < stim.size() || expq.size() > 0) && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (taken) begin
                drv_valid[m] = 1'b0;
                taken = 1'b0;
            end
            drv_en[m]   = ($urandom_range(0, 3) != 0);
            drv_ordy[m] = ($urandom_range(0, 3) != 0);
            if (!drv_valid[m]) begin
                drv_valid[m] = (idx < stim.size()) && ($urandom_range(0, 3) != 0);
            end
            if (idx < stim.size()) begin
                drv_data[m]  = stim[idx].data;
                drv_sop[m]   = stim[idx].sop;
                drv_eop[m]   = stim[idx].eop;
                drv_empty[m] = stim[idx].empty;
            end
            @(negedge clk);

            if (mon_ovld[m] && drv_ordy[m]) begin
                if (expq.size() == 0) begin
                    checkOutput("rnd_extra_beat", 1'b1, 1'b0);
                end else begin
                    o = expq.pop_front();
                    checkOutput($sformatf("rnd%0d_beat", m),
                                {mon_odata[m], mon_osop[m], mon_oeop[m], mon_oempty[m]},
                                {o.data, o.sop, o.eop, o.empty});
                end
            end
            if (perr_w[m]) act_err++;

            if (drv_valid[m] && mon_irdy[m]) begin
                b = stim[idx];
                idx++;
                taken = 1'b1;
                if (b.sop) begin
                    if (m == 0) checkOutput("block_admit", drv_en[m], 1'b1);
                    admitted = drv_en[m];
                    inpkt    = !b.eop;
                    if (admitted) expq.push_back(b);
                    if (b.eop) begin
                        if (admitted) exp_pass++;
                        else          exp_drop++;
                    end
                end else if (!inpkt) begin
                    exp_err++;
                end else begin
                    if (admitted) expq.push_back(b);
                    if (b.eop) begin
                        inpkt = 1'b0;
                        if (admitted) exp_pass++;
                        else          exp_drop++;
                    end
                end
            end
        end
        if (cyc >= 4000) checkOutput("rnd_timeout", 1'b1, 1'b0);

        drv_valid[m] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (perr_w[m]) act_err++;
        end
        checkOutput($sformatf("rnd%0d_leftover", m), 160'(expq.size()), 160'd0);
        checkOutput($sformatf("rnd%0d_proto_err", m), 160'(act_err), 160'(exp_err));
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        checkOutput($sformatf("rnd%0d_pass_cnt", m), 160'(pass_cnt_w[m]),
                    160'((exp_pass > 3) ? 3 : exp_pass));
        checkOutput($sformatf("rnd%0d_drop_cnt", m), 160'(drop_cnt_w[m]),
                    160'((exp_drop > 3) ? 3 : exp_drop));
`else
        if (exp_pass + exp_drop == 0) checkOutput("rnd_no_packets", 1'b1, 1'b0);
`endif
    endtask

    // Main sequence: BLOCK-mode vector table, hand-written multi-cycle
    // corner cases, then randomised traffic on each mode.
    initial begin
        vec_t vecs[13];
        logic [159:0] act;
        logic [159:0] exp;

        vecs[0]  = '{5'b11011, 8'hA1, 4'b1000, 8'h00, 2'b00};
        vecs[1]  = '{5'b10011, 8'hA2, 4'b1110, 8'hA1, 2'b10};
        vecs[2]  = '{5'b10101, 8'hA3, 4'b1100, 8'hA2, 2'b10};
        vecs[3]  = '{5'b11101, 8'hB1, 4'b0101, 8'hA3, 2'b00};
        vecs[4]  = '{5'b11101, 8'hB1, 4'b0001, 8'hA3, 2'b00};
        vecs[5]  = '{5'b11111, 8'hB1, 4'b1001, 8'hA3, 2'b00};
        vecs[6]  = '{5'b00010, 8'h00, 4'b0111, 8'hB1, 2'b00};
        vecs[7]  = '{5'b11010, 8'hC1, 4'b0111, 8'hB1, 2'b00};
        vecs[8]  = '{5'b11011, 8'hC1, 4'b1111, 8'hB1, 2'b00};
        vecs[9]  = '{5'b10111, 8'hC2, 4'b1110, 8'hC1, 2'b10};
        vecs[10] = '{5'b10011, 8'hD0, 4'b1101, 8'hC2, 2'b00};
        vecs[11] = '{5'b00011, 8'h00, 4'b1001, 8'hC2, 2'b01};
        vecs[12] = '{5'b00011, 8'h00, 4'b1001, 8'hC2, 2'b00};

        resetDut();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, vecs[i].in_bits[4], vecs[i].in_bits[3], vecs[i].in_bits[2],
                          vecs[i].in_bits[1], vecs[i].in_bits[0], vecs[i].d);
            act = 160'({mon_irdy[0], mon_ovld[0], mon_osop[0], mon_oeop[0], mon_odata[0],
                        mon_oempty[0], busy_w[0], perr_w[0]});
            exp = 160'({vecs[i].exp_bits, {16{vecs[i].od}}, vecs[i].od[3:0], vecs[i].bp});
            checkOutput($sformatf("vec%0d", i), act, exp);
        end

        resetDut();
        // DROP, enable low: 4-beat packet swallowed, busy from beat 2.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, (i == 0), (i == 3), 1'b0, 1'b1, 8'(8'h10 + i));
            checkOutput($sformatf("drop_beat%0d", i), {mon_irdy[1], mon_ovld[1], busy_w[1]},
                        {1'b1, 1'b0, (i != 0)});
        end
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("drop_idle", {mon_ovld[1], busy_w[1]}, 2'b00);

        // Enable falls after beat 1: the whole 5-beat packet still passes.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1'b1, (i == 0), (i == 4), (i == 0), 1'b1, 8'(8'h20 + i));
            if (i > 0) begin
                checkOutput($sformatf("mid_en_beat%0d", i - 1),
                            {mon_irdy[1], mon_ovld[1], mon_osop[1], mon_oeop[1], mon_odata[1]},
                            {1'b1, 1'b1, (i == 1), 1'b0, {16{8'(8'h20 + i - 1)}}});
            end
        end
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h28);
        checkOutput("mid_en_beat4", {mon_irdy[1], mon_ovld[1], mon_oeop[1], mon_odata[1]},
                    {1'b1, 1'b1, 1'b1, {16{8'h24}}});
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h29);
        checkOutput("next_pkt_dropped", {mon_irdy[1], mon_ovld[1], busy_w[1]}, 3'b101);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("next_pkt_gone", {mon_ovld[1], busy_w[1]}, 2'b00);

        // DROP: premature sop at beat 3 closes the open packet, new one refused.
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h30);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31);
        checkOutput("prem_d_b1", {mon_ovld[1], mon_odata[1], busy_w[1]}, {1'b1, {16{8'h30}}, 1'b1});
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32);
        checkOutput("prem_d_sop", {mon_irdy[1], mon_ovld[1], mon_odata[1], perr_w[1]},
                    {1'b1, 1'b1, {16{8'h31}}, 1'b0});
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        checkOutput("prem_d_err", {mon_irdy[1], mon_ovld[1], perr_w[1], busy_w[1]}, 4'b1011);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("prem_d_end", {mon_ovld[1], perr_w[1], busy_w[1]}, 3'b000);
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        checkOutput("drop_cnt_sat", drop_cnt_w[1], 2'd3);
        checkOutput("pass_cnt_d", pass_cnt_w[1], 2'd1);
`endif

        // BLOCK: premature sop with enable low is refused, error pulses once.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
        checkOutput("prem_b_sop", {mon_irdy[0], mon_ovld[0], mon_odata[0], busy_w[0], perr_w[0]},
                    {1'b0, 1'b1, {16{8'h41}}, 1'b1, 1'b0});
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
        checkOutput("prem_b_err", {mon_irdy[0], busy_w[0], perr_w[0]}, 3'b001);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
        checkOutput("prem_b_once", {mon_irdy[0], perr_w[0]}, 2'b00);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
        checkOutput("prem_b_admit", {mon_irdy[0], mon_ovld[0]}, 2'b10);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("prem_b_out", {mon_ovld[0], mon_osop[0], mon_oeop[0], mon_odata[0]},
                    {3'b111, {16{8'h42}}});
`ifdef AVALON_ST_PACKET_GATE_STATS_EN
        checkOutput("cnt_b", {pass_cnt_w[0], drop_cnt_w[0]}, 4'b0101);
`endif

        resetDut();
        runRandom(0);
        resetDut();
        runRandom(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
